// File: rtl/data_memory_lanes_if.sv
// Load/store request/response bus between the datapath LSU and data_memory_lanes.
interface data_memory_lanes_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_write;
  logic                  mem_read;
  logic [1:0]            size;
  logic                  unsigned_ld;
  logic [31:0]           address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  resp_valid;
  logic                  fault;

  modport master (
    output req_valid, mem_write, mem_read, size, unsigned_ld, address, write_data,
    input  req_ready, read_data, resp_valid, fault
  );

  modport slave (
    input  req_valid, mem_write, mem_read, size, unsigned_ld, address, write_data,
    output req_ready, read_data, resp_valid, fault
  );

endinterface

// File: rtl/data_memory_lanes.sv
// Data memory with little-endian byte lanes, sub-word loads/stores, sign/zero
// extension, relocatable base address and a registered req/resp handshake with
// WAIT_STATES extra cycles per access.
// Optional feature macro: MEM_FAULT_EN (alignment / range faults). Without it,
// fault is constant 0, the word index wraps and sub-alignment bits are dropped.
// MEMORY_DEPTH is expected to be a power of two.
module data_memory_lanes #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int unsigned WAIT_STATES  = 0
) (
  input logic               clk,
  input logic               reset,
  data_memory_lanes_if.slave bus
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned LANE_W = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(MEMORY_DEPTH);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  uns_q, uns_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  fault_q, fault_d;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [31:0]           offset_c;
  logic [1:0]            size_e_c;
  logic [3:0]            nbytes_c;
  logic [LANE_W-1:0]     lane_c;
  logic [LANE_W-1:0]     lane_mask_c;
  logic [LANE_W-1:0]     lane_a_c;
  logic [IDX_W-1:0]      idx_c;
  logic [NB-1:0]         be_c;
  logic [DATA_WIDTH-1:0] wshift_c;
  logic [DATA_WIDTH-1:0] rword_c;
  logic [DATA_WIDTH-1:0] rshift_c;
  logic [DATA_WIDTH-1:0] ext_mask_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic                  sign_c;
  logic                  fault_c;
  logic                  we_c;
  logic                  unused_offset_c;

  // Offset bits above the word index only matter for the range fault.
  assign unused_offset_c = ^offset_c;

  // Address decode, lane enables, load extraction/extension and fault detect.
  always_comb begin
    offset_c    = addr_q - BASE_ADDR;
    size_e_c    = (DATA_WIDTH == 32 && size_q == 2'b11) ? 2'b10 : size_q;
    nbytes_c    = 4'd1 << size_e_c;
    lane_c      = offset_c[LANE_W-1:0];
    lane_mask_c = LANE_W'(nbytes_c - 4'd1);
    lane_a_c    = lane_c & ~lane_mask_c;
    idx_c       = offset_c[LANE_W +: IDX_W];

    be_c       = '0;
    ext_mask_c = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be_c[i] = (4'(i) >= 4'(lane_a_c)) && (4'(i) < 4'(lane_a_c) + nbytes_c);
      ext_mask_c[8*i +: 8] = (4'(i) < nbytes_c) ? 8'hFF : 8'h00;
    end

    wshift_c = wdata_q << {lane_a_c, 3'b000};
    rword_c  = mem[idx_c];
    rshift_c = rword_c >> {lane_a_c, 3'b000};

    sign_c = 1'b0;
    case (size_e_c)
      2'b00:   sign_c = rshift_c[7];
      2'b01:   sign_c = rshift_c[15];
      2'b10:   sign_c = rshift_c[31];
      default: sign_c = rshift_c[DATA_WIDTH-1];
    endcase

    load_c = rshift_c & ext_mask_c;
    if (!uns_q && sign_c) begin
      load_c = load_c | ~ext_mask_c;
    end

`ifdef MEM_FAULT_EN
    fault_c = (wr_q || rd_q) &&
              ((|(lane_c & lane_mask_c)) || ((offset_c >> LANE_W) >= 32'(MEMORY_DEPTH)));
`else
    fault_c = 1'b0;
`endif

    we_c = (state_q == ST_ACCESS) && wr_q && !fault_c;
  end

  // Next-state, request capture and response register computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    uns_d       = uns_q;
    read_data_d = read_data_q;
    fault_d     = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.address;
          wdata_d = bus.write_data;
          size_d  = bus.size;
          wr_d    = bus.mem_write;
          rd_d    = bus.mem_read;
          uns_d   = bus.unsigned_ld;
          cnt_d   = '0;
          state_d = (WAIT_STATES != 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_STATES - 1)) begin
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        read_data_d = (rd_q && !wr_q && !fault_c) ? load_c : '0;
        fault_d     = fault_c;
        state_d     = ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // Control and response registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      uns_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      read_data_q  <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      uns_q        <= uns_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      read_data_q  <= read_data_d;
      fault_q      <= fault_d;
    end
  end

  // RAM array: store commits only the enabled byte lanes on the ACCESS exit edge.
  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be_c[i]) begin
          mem[idx_c][8*i +: 8] <= wshift_c[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.read_data  = read_data_q;
  assign bus.fault      = fault_q;

endmodule
